iter_divider: RTL and testbench

Iterative radix-2 restoring integer divider, the responder side of the MDU divide handshake. It accepts one 32-bit dividend/divisor pair through a valid/ready request channel and computes quotient and remainder one bit per cycle. It returns the results through a valid/ready response channel. It sits inside the MDU at the M2 stage, and the MDU pulls rst_n low to abort a divide on pipeline flush.

---
 rtl/iter_divider_pkg.sv | 24 ++
 rtl/iter_divider_lzc.sv | 20 ++
 rtl/iter_divider.sv | 189 ++++++++++++++++++
 tb/tb_iter_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_t    : divider FSM state encoding (IDLE / CALC / DONE)
//   DIV_DATA_WIDTH : operand/result width (only 32 is supported)
//   DIV_CNT_W      : iteration counter width, wide enough to hold DATA_WIDTH
//   div_abs()      : two's-complement magnitude when neg is set, raw value otherwise
package iter_divider_pkg;

   localparam int DIV_DATA_WIDTH = 32;
   localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic [DIV_DATA_WIDTH-1:0] div_abs(
      input logic                      neg,
      input logic [DIV_DATA_WIDTH-1:0] v
   );
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/iter_divider_lzc.sv
// div_lzc32: combinational 32-bit leading-zero counter.
//   a_i  [31:0] : value to scan
//   lz_o [5:0]  : number of leading zeros, 32 when a_i is zero
// Only instantiated when the divider is built with DIV_EARLY_TERM_EN.
module div_lzc32 (
   input  logic [31:0] a_i,
   output logic [5:0]  lz_o
);

   // Scan from LSB upward so the highest set bit writes last and wins.
   always_comb begin
      lz_o = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (a_i[i]) begin
            lz_o = 6'(31 - i);
         end
      end
   end

endmodule

// File: rtl/iter_divider.sv
// iter_divider: iterative radix-2 restoring divider, one quotient bit per cycle.
// Request channel : div_valid / div_ready, div_signed_i, Z_i (dividend), D_i (divisor)
// Response channel: res_valid / res_ready, q_o (quotient), s_o (remainder)
// clk, rst_n      : clock and synchronous active-low reset (also aborts a divide)
// Build option    : DIV_EARLY_TERM_EN skips leading-zero iterations of the dividend.
//
// state | meaning
// IDLE  | waiting for a request, div_ready high
// CALC  | one restoring step per cycle, counter counts down to the last step
// DONE  | result registered, res_valid high until res_ready
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  div_valid,
   output logic                  div_ready,
   input  logic                  div_signed_i,
   input  logic [DATA_WIDTH-1:0] Z_i,
   input  logic [DATA_WIDTH-1:0] D_i,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] q_o,
   output logic [DATA_WIDTH-1:0] s_o
);

   div_state_t state_q, state_d;

   logic [DATA_WIDTH:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] rmd_q, rmd_d;
   logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  div0_q, div0_d;

   logic                  accept;
   logic                  last_step;
   logic                  z_neg, d_neg, d_zero;
   logic [DATA_WIDTH-1:0] z_abs, d_abs;
   logic [DATA_WIDTH-1:0] dvd_init;
   logic [DIV_CNT_W-1:0]  cnt_init;
   logic [DATA_WIDTH:0]   rem_sh;
   logic                  q_bit;
   logic [DATA_WIDTH:0]   step_rem;
   logic [DATA_WIDTH-1:0] step_quo;

   assign accept    = div_valid & div_ready;
   assign last_step = (state_q == CALC) && (cnt_q == DIV_CNT_W'(1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = CALC;
         CALC:    if (last_step) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      div_ready = (state_q == IDLE);
      res_valid = (state_q == DONE);
   end

   assign q_o = quo_q;
   assign s_o = rmd_q;

   // ---------------- operand preparation ----------------
   assign z_neg  = div_signed_i & Z_i[DATA_WIDTH-1];
   assign d_neg  = div_signed_i & D_i[DATA_WIDTH-1];
   assign d_zero = (D_i == '0);
   assign z_abs  = div_abs(z_neg, Z_i);
   assign d_abs  = div_abs(d_neg, D_i);

`ifdef DIV_EARLY_TERM_EN
   logic [5:0]           z_lz;
   logic [DIV_CNT_W-1:0] n_iter;

   div_lzc32 u_lzc (
      .a_i  (z_abs),
      .lz_o (z_lz)
   );

   // Only the significant bits of |Z| need a step; the dividend is pre-shifted
   // so its top significant bit is the first one shifted into the remainder.
   always_comb begin
      if (d_zero || (z_lz == 6'd32)) begin
         n_iter = DIV_CNT_W'(1);
      end else begin
         n_iter = DIV_CNT_W'(DATA_WIDTH) - DIV_CNT_W'(z_lz);
      end
      cnt_init = n_iter;
      dvd_init = z_abs << (DIV_CNT_W'(DATA_WIDTH) - n_iter);
   end
`else
   assign cnt_init = DIV_CNT_W'(DATA_WIDTH);
   assign dvd_init = z_abs;
`endif

   // ---------------- restoring step ----------------
   // rem_q's top bit is the carry of a previous shift; it cannot be set for a
   // legal divisor, but folding it into q_bit keeps the compare exact anyway.
   always_comb begin
      rem_sh   = {rem_q[DATA_WIDTH-1:0], dvd_q[DATA_WIDTH-1]};
      q_bit    = rem_q[DATA_WIDTH] | (rem_sh >= {1'b0, dvs_q});
      step_rem = q_bit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
      step_quo = {dvd_q[DATA_WIDTH-2:0], q_bit};
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      rmd_d     = rmd_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;

      if (accept) begin
         rem_d     = '0;
         dvd_d     = dvd_init;
         cnt_d     = cnt_init;
         neg_quo_d = z_neg ^ d_neg;
         neg_rem_d = z_neg;
         div0_d    = d_zero;
         // A zero divisor makes the divisor register free; park the raw
         // dividend there so it can be returned as the remainder unchanged.
         dvs_d     = d_zero ? Z_i : d_abs;
      end else if (state_q == CALC) begin
         rem_d = step_rem;
         dvd_d = step_quo;
         cnt_d = cnt_q - DIV_CNT_W'(1);
         if (last_step) begin
            if (div0_q) begin
               quo_d = '1;
               rmd_d = dvs_q;
            end else begin
               quo_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
               rmd_d = neg_rem_q ? (~step_rem[DATA_WIDTH-1:0] + 1'b1)
                                 : step_rem[DATA_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         rmd_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         rmd_q     <= rmd_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases, backpressure,
// mid-divide abort and randomized divides against an arithmetic reference.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic        div_signed_i = 1'b0;
   logic [31:0] Z_i = '0;
   logic [31:0] D_i = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] q_o;
   logic [31:0] s_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   iter_divider #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .div_valid    (div_valid),
      .div_ready    (div_ready),
      .div_signed_i (div_signed_i),
      .Z_i          (Z_i),
      .D_i          (D_i),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .q_o          (q_o),
      .s_o          (s_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division in 64-bit arithmetic (truncating,
   // remainder follows dividend), plus the divide-by-zero convention.
   task automatic ref_div(input logic sg, input logic [31:0] z, input logic [31:0] d,
                          output logic [31:0] eq, output logic [31:0] es, output int elat);
      longint zz, dd;
      if (d == 32'd0) begin
         eq = 32'hFFFF_FFFF;
         es = z;
      end else begin
         zz = sg ? longint'($signed(z)) : longint'(z);
         dd = sg ? longint'($signed(d)) : longint'(d);
         eq = 32'(zz / dd);
         es = 32'(zz % dd);
      end
`ifdef DIV_EARLY_TERM_EN
      begin
         logic [31:0] mag;
         int          nb;
         mag = (sg && z[31]) ? (32'd0 - z) : z;
         nb  = 0;
         for (int i = 0; i < 32; i++) if (mag[i]) nb = i + 1;
         if (nb < 1 || d == 32'd0) nb = 1;
         elat = nb + 1;
      end
`else
      elat = 33;
`endif
   endtask

   task automatic run_div(input string tag, input logic sg, input logic [31:0] z,
                          input logic [31:0] d, input int hold);
      logic [31:0] eq, es;
      int          elat, lat;
      ref_div(sg, z, d, eq, es, elat);
      @(negedge clk);
      check({tag, ".ready_idle"}, 32'(div_ready), 32'd1);
      div_valid    = 1'b1;
      div_signed_i = sg;
      Z_i          = z;
      D_i          = d;
      res_ready    = (hold == 0);
      @(negedge clk);
      div_valid = 1'b0;
      Z_i       = $urandom;
      D_i       = $urandom;
      lat = 1;
      while (!res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(elat));
      check({tag, ".q"}, q_o, eq);
      check({tag, ".s"}, s_o, es);
      check({tag, ".ready_busy"}, 32'(div_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         check({tag, ".hold_valid"}, 32'(res_valid), 32'd1);
         check({tag, ".hold_q"}, q_o, eq);
         check({tag, ".hold_s"}, s_o, es);
         check({tag, ".hold_ready"}, 32'(div_ready), 32'd0);
         div_valid = 1'b1;
         Z_i       = $urandom;
         D_i       = $urandom;
         @(negedge clk);
      end
      div_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check({tag, ".valid_drop"}, 32'(res_valid), 32'd0);
      check({tag, ".ready_back"}, 32'(div_ready), 32'd1);
   endtask

   initial begin
      logic        sg;
      logic [31:0] z, d;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.div_ready", 32'(div_ready), 32'd1);
      check("rst.res_valid", 32'(res_valid), 32'd0);
      check("rst.q", q_o, 32'd0);
      check("rst.s", s_o, 32'd0);
      rst_n = 1'b1;

      run_div("u100_7",   1'b0, 32'd100,       32'd7,         0);
      run_div("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         0);
      run_div("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 0);
      run_div("uF9_2",    1'b0, 32'hFFFF_FFF9, 32'd2,         0);
      run_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_div("u_div0",   1'b0, 32'h0000_1234, 32'd0,         0);
      run_div("s_div0",   1'b1, 32'hFFFF_FF00, 32'd0,         0);
      run_div("bp",       1'b1, 32'hFFFF_F000, 32'd9,         5);
      run_div("after_bp", 1'b0, 32'd1000,      32'd33,        0);
      run_div("u5_1",     1'b0, 32'd5,         32'd1,         0);
      run_div("uFF_3",    1'b0, 32'hFFFF_FFFF, 32'd3,         0);
      run_div("u0_7",     1'b0, 32'd0,         32'd7,         0);

      // Abort: reset for one cycle at CALC cycle 10.
      @(negedge clk);
      div_valid    = 1'b1;
      div_signed_i = 1'b0;
      Z_i          = 32'hFFFF_FFFF;
      D_i          = 32'd3;
      @(negedge clk);
      div_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort.pre_valid", 32'(res_valid), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort.div_ready", 32'(div_ready), 32'd1);
      check("abort.res_valid", 32'(res_valid), 32'd0);
      check("abort.q", q_o, 32'd0);
      check("abort.s", s_o, 32'd0);
      run_div("u50_5", 1'b0, 32'd50, 32'd5, 0);

      for (int k = 0; k < 24; k++) begin
         sg = 1'($urandom_range(0, 1));
         z  = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) z = 32'd0 - z;
         case ($urandom_range(0, 3))
            0:       d = $urandom;
            1:       d = 32'($urandom_range(1, 15));
            2:       d = 32'd0 - 32'($urandom_range(1, 9));
            default: d = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         run_div($sformatf("rnd%0d", k), sg, z, d, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
